// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
//  Module      : program_counter
//  Description : SAP-1 program counter. Holds the address of the next
//                instruction to fetch. It counts up by one on each rising
//                edge of CLK_bar while Cp is high, and it places the count on
//                the shared W bus while Ep is high.
//
//  Ports
//    CLK_bar  in   1          inverted system clock; state changes on its
//                             rising edge, which is the falling edge of the
//                             system clock
//    CLR_bar  in   1          asynchronous active-low clear of the count
//    Cp       in   1          count enable, sampled at the clock edge
//    Ep       in   1          bus output enable, combinational
//    W_bus    out  BUS_WIDTH  count zero-extended when Ep=1, else high-Z
//
//  Revision    : 1.0  initial release
// ============================================================================
module program_counter #(
    parameter int WIDTH     = 4,
    parameter int BUS_WIDTH = 8
) (
    input  logic                 CLK_bar,
    input  logic                 CLR_bar,
    input  logic                 Cp,
    input  logic                 Ep,
    output logic [BUS_WIDTH-1:0] W_bus
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    // A narrower bus than the counter would silently drop address bits.
    generate
        if (BUS_WIDTH < WIDTH) begin : g_bad_width
            $error("program_counter: BUS_WIDTH (%0d) must be >= WIDTH (%0d)",
                   BUS_WIDTH, WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0]     count_q;
    logic [WIDTH-1:0]     count_d;
    logic [BUS_WIDTH-1:0] w_count_ext;

    // Next count. The natural overflow of the WIDTH-bit add provides the
    // wrap from all ones back to zero.
    always_comb begin
        count_d = count_q;
        if (Cp) begin
            count_d = count_q + c_ONE;
        end
    end

    // The clear is asynchronous and overrides any count request.
    always_ff @(posedge CLK_bar or negedge CLR_bar) begin
        if (!CLR_bar) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The width cast zero-extends, and it also covers BUS_WIDTH == WIDTH,
    // where a zero-length replication would be illegal.
    assign w_count_ext = BUS_WIDTH'(count_q);

    // The bus is released whenever Ep is low so other modules can drive W.
    assign W_bus = Ep ? w_count_ext : {BUS_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_counter
//  Description : Directed self-checking bench for program_counter. The bus
//                carries a pull-up, so a released bus reads as 8'hFF. A
//                driven value always has a zero upper nibble, so it can never
//                read as 8'hFF.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_program_counter;

    logic       CLK_bar;
    logic       CLR_bar;
    logic       Cp;
    logic       Ep;
    wire  [7:0] W_bus;

    int n_total;
    int n_bad;

    localparam logic [7:0] c_HIZ = 8'hFF;

    pullup (W_bus);

    program_counter #(
        .WIDTH     (4),
        .BUS_WIDTH (8)
    ) u_dut (
        .CLK_bar (CLK_bar),
        .CLR_bar (CLR_bar),
        .Cp      (Cp),
        .Ep      (Ep),
        .W_bus   (W_bus)
    );

    initial CLK_bar = 1'b0;
    always #10 CLK_bar = ~CLK_bar;

    task automatic check_val(input string tag, input logic [7:0] got,
                             input logic [7:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait n rising edges, then step 1 ns past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge CLK_bar);
        #1;
    endtask

    // Pulse Ep, sample the bus, then release it again.
    task automatic peek(input string tag, input logic [7:0] exp);
        Ep = 1'b1;
        #1;
        check_val(tag, W_bus, exp);
        Ep = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        CLR_bar = 1'b0;
        Cp      = 1'b0;
        Ep      = 1'b0;

        // Reset state.
        #100;
        check_val("reset_hiz", W_bus, c_HIZ);
        peek("reset_ep", 8'h00);

        // Cp edges while the clear is held must not count.
        Cp = 1'b1;
        edges(2);
        Cp = 1'b0;
        peek("reset_over_cp", 8'h00);

        // Release the clear between clock edges.
        @(posedge CLK_bar);
        #5 CLR_bar = 1'b1;
        edges(1);
        peek("after_release", 8'h00);

        // T1: Ep=1 and Cp=0 for 60 ns.
        Ep = 1'b1;
        edges(3);
        check_val("t1_bus", W_bus, 8'h00);
        Ep = 1'b0;
        #1;
        check_val("t1_release", W_bus, c_HIZ);

        // T2: Cp=1 for 120 ns gives 6 edges. The bus stays released.
        Cp = 1'b1;
        edges(3);
        check_val("t2_hiz", W_bus, c_HIZ);
        edges(3);
        Cp = 1'b0;
        peek("t2_count", 8'h06);

        // Idle for 180 ns: the count holds.
        edges(9);
        peek("idle_hold", 8'h06);

        // Repeated cycles with 1 and then 2 T2 edges.
        Cp = 1'b1;
        edges(1);
        Cp = 1'b0;
        peek("cycle_a", 8'h07);
        Cp = 1'b1;
        edges(2);
        Cp = 1'b0;
        peek("cycle_b", 8'h09);

        // A Cp glitch between edges is ignored.
        @(posedge CLK_bar);
        #3 Cp = 1'b1;
        #4 Cp = 1'b0;
        edges(1);
        peek("glitch", 8'h09);

        // Async clear mid-count, from 9, between edges.
        @(posedge CLK_bar);
        #5 CLR_bar = 1'b0;
        #1;
        peek("async_clr", 8'h00);
        Cp = 1'b1;
        edges(2);
        peek("clr_cp_edges", 8'h00);
        Cp = 1'b0;
        @(posedge CLK_bar);
        #5 CLR_bar = 1'b1;

        // Wrap: count up to 15, then one more edge.
        Cp = 1'b1;
        edges(15);
        Cp = 1'b0;
        peek("at_15", 8'h0F);
        Cp = 1'b1;
        edges(1);
        Cp = 1'b0;
        peek("wrap", 8'h00);

        // Ep and Cp together at count 3.
        Cp = 1'b1;
        edges(3);
        Ep = 1'b1;
        #1;
        check_val("both_pre", W_bus, 8'h03);
        edges(1);
        check_val("both_post", W_bus, 8'h04);
        Cp = 1'b0;
        edges(1);
        check_val("both_hold", W_bus, 8'h04);
        Ep = 1'b0;
        #1;
        check_val("final_hiz", W_bus, c_HIZ);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
